// File: rtl/ucisc_pkg.sv
// Shared select encoding, reset/step defaults and sizing helpers for the register file.
package ucisc_pkg;

    // Register select value that addresses the program counter
    localparam int unsigned SEL_PC = 0;

    // Default reset and step constants (16-bit machine)
    localparam int unsigned DEF_WIDTH      = 16;
    localparam logic [15:0] DEF_PC_INIT    = 16'hFFFE;
    localparam logic [15:0] DEF_PC_STEP    = 16'h0002;
    localparam logic [15:0] DEF_FLAGS_INIT = 16'h0100;
    localparam logic [15:0] DEF_INC_STEP   = 16'h0001;

    // Bank index width; a single bank still needs one bit
    function automatic int unsigned bank_bits(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dff.sv
// Enabled register with asynchronous active-high reset to a parameterised value.
module dff #(
    parameter int unsigned     W       = 1,
    parameter logic [W-1:0]    RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Hold unless enabled; reset wins asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/banked_reg_file.sv
// Banked general register file with shared PC and flags; all state lives in dff instances.
module banked_reg_file
    import ucisc_pkg::*;
#(
    parameter int unsigned        WIDTH      = DEF_WIDTH,
    parameter int unsigned        NUM_REGS   = 6,
    parameter int unsigned        NUM_BANKS  = 2,
    parameter logic [WIDTH-1:0]   PC_INIT    = WIDTH'(DEF_PC_INIT),
    parameter logic [WIDTH-1:0]   PC_STEP    = WIDTH'(DEF_PC_STEP),
    parameter logic [WIDTH-1:0]   FLAGS_INIT = WIDTH'(DEF_FLAGS_INIT),
    parameter logic [WIDTH-1:0]   INC_STEP   = WIDTH'(DEF_INC_STEP),
    localparam int unsigned       SELW       = $clog2(NUM_REGS + 1),
    localparam int unsigned       BW         = bank_bits(NUM_BANKS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             commit,
    input  logic             wr_en,
    input  logic [SELW-1:0]  wr_sel,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             inc_en,
    input  logic [SELW-1:0]  inc_sel,
    input  logic             inc_dir,
    input  logic             flags_wr,
    input  logic [WIDTH-1:0] flags_in,
    input  logic             bank_swap,
    input  logic [BW-1:0]    bank_next,
    input  logic [SELW-1:0]  rd_sel_a,
    input  logic [SELW-1:0]  rd_sel_b,
    output logic [WIDTH-1:0] rd_data_a,
    output logic [WIDTH-1:0] rd_data_b,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] flags_out,
    output logic [BW-1:0]    bank_out
);

    logic             rst;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_d;
    logic             pc_load;
    logic [WIDTH-1:0] flags;
    logic [BW-1:0]    bank;
    logic             bank_en;
    logic [WIDTH-1:0] regs [NUM_BANKS][NUM_REGS];

    // dff resets are active-high
    assign rst = ~reset;

    // PC: explicit load via select 0, otherwise advance on every commit
    assign pc_load = wr_en && (wr_sel == SELW'(SEL_PC));
    assign pc_d    = pc_load ? wr_data : pc + PC_STEP;

    dff #(.W(WIDTH), .RST_VAL(PC_INIT)) u_pc (
        .clk (clock),
        .rst (rst),
        .en  (commit),
        .d   (pc_d),
        .q   (pc)
    );

    dff #(.W(WIDTH), .RST_VAL(FLAGS_INIT)) u_flags (
        .clk (clock),
        .rst (rst),
        .en  (commit && flags_wr),
        .d   (flags_in),
        .q   (flags)
    );

    // Out-of-range bank requests are dropped
    assign bank_en = commit && bank_swap && (32'(bank_next) < NUM_BANKS);

    dff #(.W(BW), .RST_VAL('0)) u_bank (
        .clk (clock),
        .rst (rst),
        .en  (bank_en),
        .d   (bank_next),
        .q   (bank)
    );

    // One dff per bank/register; same-commit updates see the old bank
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
            logic             active;
            logic             wr_hit;
            logic             inc_hit;
            logic [WIDTH-1:0] nxt;

            assign active  = (bank == BW'(b));
            assign wr_hit  = active && wr_en  && (wr_sel  == SELW'(r + 1));
            assign inc_hit = active && inc_en && (inc_sel == SELW'(r + 1));
            // Write beats an adjust aimed at the same register
            assign nxt     = wr_hit  ? wr_data :
                             inc_dir ? regs[b][r] - INC_STEP :
                                       regs[b][r] + INC_STEP;

            dff #(.W(WIDTH), .RST_VAL('0)) u_reg (
                .clk (clock),
                .rst (rst),
                .en  (commit && (wr_hit || inc_hit)),
                .d   (nxt),
                .q   (regs[b][r])
            );
        end
    end

    // Read ports: PC, active-bank register, or zero for unused selects
    always_comb begin
        rd_data_a = '0;
        rd_data_b = '0;
        if (rd_sel_a == SELW'(SEL_PC)) rd_data_a = pc;
        if (rd_sel_b == SELW'(SEL_PC)) rd_data_b = pc;
        for (int b = 0; b < NUM_BANKS; b++) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (bank == BW'(b) && rd_sel_a == SELW'(r + 1)) rd_data_a = regs[b][r];
                if (bank == BW'(b) && rd_sel_b == SELW'(r + 1)) rd_data_b = regs[b][r];
            end
        end
    end

    assign pc_out    = pc;
    assign flags_out = flags;
    assign bank_out  = bank;

endmodule

// File: tb/tb_banked_reg_file.sv
// Bench for banked_reg_file: directed scenarios plus random traffic against an array model.
module tb_banked_reg_file;

    localparam int unsigned NB   = 3;
    localparam int unsigned NR   = 6;
    localparam int unsigned SELW = 3;
    localparam int unsigned BW   = 2;

    logic             clock = 1'b0;
    logic             reset;
    logic             commit;
    logic             wr_en;
    logic [SELW-1:0]  wr_sel;
    logic [15:0]      wr_data;
    logic             inc_en;
    logic [SELW-1:0]  inc_sel;
    logic             inc_dir;
    logic             flags_wr;
    logic [15:0]      flags_in;
    logic             bank_swap;
    logic [BW-1:0]    bank_next;
    logic [SELW-1:0]  rd_sel_a;
    logic [SELW-1:0]  rd_sel_b;
    logic [15:0]      rd_data_a;
    logic [15:0]      rd_data_b;
    logic [15:0]      pc_out;
    logic [15:0]      flags_out;
    logic [BW-1:0]    bank_out;

    int total = 0;
    int bad   = 0;

    // Reference state
    logic [15:0] m_pc;
    logic [15:0] m_flags;
    int          m_bank;
    logic [15:0] m_regs [0:3][0:7];

    banked_reg_file #(.NUM_BANKS(NB)) dut (
        .clock     (clock),
        .reset     (reset),
        .commit    (commit),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .wr_data   (wr_data),
        .inc_en    (inc_en),
        .inc_sel   (inc_sel),
        .inc_dir   (inc_dir),
        .flags_wr  (flags_wr),
        .flags_in  (flags_in),
        .bank_swap (bank_swap),
        .bank_next (bank_next),
        .rd_sel_a  (rd_sel_a),
        .rd_sel_b  (rd_sel_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .pc_out    (pc_out),
        .flags_out (flags_out),
        .bank_out  (bank_out)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_rd(input int sel);
        if (sel == 0) return m_pc;
        if (sel <= NR) return m_regs[m_bank][sel];
        return 16'h0000;
    endfunction

    task automatic model_reset();
        m_pc    = 16'hFFFE;
        m_flags = 16'h0100;
        m_bank  = 0;
        for (int b = 0; b < 4; b++)
            for (int r = 0; r < 8; r++)
                m_regs[b][r] = 16'h0000;
    endtask

    // One committed update computed from the rules on current inputs
    task automatic model_commit();
        int ws;
        int is;
        ws = int'(wr_sel);
        is = int'(inc_sel);
        m_pc = (wr_en && ws == 0) ? wr_data : m_pc + 16'd2;
        if (wr_en && ws >= 1 && ws <= NR)
            m_regs[m_bank][ws] = wr_data;
        if (inc_en && is >= 1 && is <= NR && !(wr_en && ws == is))
            m_regs[m_bank][is] = inc_dir ? m_regs[m_bank][is] - 16'd1
                                         : m_regs[m_bank][is] + 16'd1;
        if (flags_wr) m_flags = flags_in;
        if (bank_swap && int'(bank_next) < NB) m_bank = int'(bank_next);
    endtask

    task automatic idle();
        commit    = 1'b0;
        wr_en     = 1'b0;
        wr_sel    = '0;
        wr_data   = '0;
        inc_en    = 1'b0;
        inc_sel   = '0;
        inc_dir   = 1'b0;
        flags_wr  = 1'b0;
        flags_in  = '0;
        bank_swap = 1'b0;
        bank_next = '0;
        rd_sel_a  = '0;
        rd_sel_b  = '0;
    endtask

    // Called just after a falling edge with inputs set: check, advance model, move one cycle
    task automatic step();
        #1;
        chk("rd_a",  32'(rd_data_a), 32'(model_rd(int'(rd_sel_a))));
        chk("rd_b",  32'(rd_data_b), 32'(model_rd(int'(rd_sel_b))));
        chk("pc",    32'(pc_out),    32'(m_pc));
        chk("flags", 32'(flags_out), 32'(m_flags));
        chk("bank",  32'(bank_out),  32'(m_bank));
        if (commit && reset) model_commit();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic peek(input string tag, input int sel, input logic [15:0] exp);
        rd_sel_a = SELW'(sel);
        #1;
        chk(tag, 32'(rd_data_a), 32'(exp));
    endtask

    initial begin
        idle();
        reset = 1'b0;
        model_reset();
        @(negedge clock);
        @(negedge clock);

        // Reset values
        chk("rst_pc",    32'(pc_out),    32'hFFFE);
        chk("rst_flags", 32'(flags_out), 32'h0100);
        chk("rst_bank",  32'(bank_out),  32'h0);
        for (int s = 1; s <= NR; s++) peek("rst_reg", s, 16'h0000);
        reset = 1'b1;

        // Idle commits advance the PC from its reset value
        idle();
        step();
        commit = 1'b1;
        step(); chk("pc_seq0", 32'(pc_out), 32'h0000);
        step(); chk("pc_seq1", 32'(pc_out), 32'h0002);
        step(); chk("pc_seq2", 32'(pc_out), 32'h0004);

        // Write then push/pop r1
        idle(); commit = 1'b1; wr_en = 1'b1; wr_sel = 3'd1; wr_data = 16'h0010;
        step(); peek("r1_wr", 1, 16'h0010);
        idle(); commit = 1'b1; inc_en = 1'b1; inc_sel = 3'd1; inc_dir = 1'b1;
        step(); peek("r1_push", 1, 16'h000F);
        idle(); commit = 1'b1; inc_en = 1'b1; inc_sel = 3'd1; inc_dir = 1'b0;
        step(); peek("r1_pop", 1, 16'h0010);

        // Wrap in both directions
        idle(); commit = 1'b1; wr_en = 1'b1; wr_sel = 3'd2; wr_data = 16'h0000;
        step();
        idle(); commit = 1'b1; inc_en = 1'b1; inc_sel = 3'd2; inc_dir = 1'b1;
        step(); peek("r2_wrap", 2, 16'hFFFF);
        idle(); commit = 1'b1; wr_en = 1'b1; wr_sel = 3'd3; wr_data = 16'hFFFF;
        step();
        idle(); commit = 1'b1; inc_en = 1'b1; inc_sel = 3'd3; inc_dir = 1'b0;
        step(); peek("r3_wrap", 3, 16'h0000);

        // Write priority on collision, both applied otherwise
        idle(); commit = 1'b1; wr_en = 1'b1; wr_sel = 3'd4; wr_data = 16'h1234;
        inc_en = 1'b1; inc_sel = 3'd4; inc_dir = 1'b1;
        step(); peek("r4_prio", 4, 16'h1234);
        idle(); commit = 1'b1; wr_en = 1'b1; wr_sel = 3'd5; wr_data = 16'h0020;
        step();
        idle(); commit = 1'b1; wr_en = 1'b1; wr_sel = 3'd4; wr_data = 16'h1234;
        inc_en = 1'b1; inc_sel = 3'd5; inc_dir = 1'b1;
        step(); peek("r4_both", 4, 16'h1234); peek("r5_both", 5, 16'h001F);

        // Bank swap: same-commit write goes to the old bank
        idle(); commit = 1'b1; wr_en = 1'b1; wr_sel = 3'd1; wr_data = 16'hAAAA;
        step();
        idle(); commit = 1'b1; wr_en = 1'b1; wr_sel = 3'd1; wr_data = 16'h5555;
        bank_swap = 1'b1; bank_next = 2'd1;
        step(); chk("swap_bank", 32'(bank_out), 32'h1); peek("swap_r1_new", 1, 16'h0000);
        idle(); commit = 1'b1; bank_swap = 1'b1; bank_next = 2'd0;
        step(); chk("swap_back", 32'(bank_out), 32'h0); peek("swap_r1_old", 1, 16'h5555);
        idle(); commit = 1'b1; bank_swap = 1'b1; bank_next = 2'd3;
        step(); chk("swap_ign", 32'(bank_out), 32'h0); peek("swap_ign_r1", 1, 16'h5555);
        idle(); commit = 1'b1; bank_swap = 1'b1; bank_next = 2'd3;
        commit = 1'b0;
        step(); chk("hold_bank", 32'(bank_out), 32'h0);

        // Reset mid-stream with a PC load pending
        idle(); commit = 1'b1; wr_en = 1'b1; wr_sel = 3'd0; wr_data = 16'h4000;
        #2 reset = 1'b0;
        #1 chk("async_rst_pc", 32'(pc_out), 32'hFFFE);
        model_reset();
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        idle();
        step(); step();
        chk("post_rst_hold", 32'(pc_out), 32'hFFFE);

        // Random traffic, occasional reset pulses
        for (int i = 0; i < 2000; i++) begin
            commit    = ($urandom_range(0, 9) < 7);
            wr_en     = 1'($urandom_range(0, 1));
            wr_sel    = SELW'($urandom_range(0, 7));
            wr_data   = 16'($urandom);
            inc_en    = 1'($urandom_range(0, 1));
            inc_sel   = SELW'($urandom_range(0, 7));
            inc_dir   = 1'($urandom_range(0, 1));
            flags_wr  = ($urandom_range(0, 3) == 0);
            flags_in  = 16'($urandom);
            bank_swap = ($urandom_range(0, 4) == 0);
            bank_next = BW'($urandom_range(0, 3));
            rd_sel_a  = SELW'($urandom_range(0, 7));
            rd_sel_b  = SELW'($urandom_range(0, 7));
            if ($urandom_range(0, 199) == 0) begin
                reset = 1'b0;
                model_reset();
                step();
                reset = 1'b1;
            end else begin
                step();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
